// File: rtl/wb_regfile.sv
// Dual-lane write-back register file with a 32-cycle clear sweep after reset.
// Optional same-cycle write-to-read bypass enabled by defining RF_WB_BYPASS_EN.
module wb_regfile #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst0_wb_valid_i,
    input  logic [4:0]      inst0_wb_rd_i,
    input  logic [XLEN-1:0] inst0_wb_value_i,
    input  logic            inst1_wb_valid_i,
    input  logic [4:0]      inst1_wb_rd_i,
    input  logic [XLEN-1:0] inst1_wb_value_i,
    input  logic [4:0]      inst0_rs1_addr_i,
    input  logic [4:0]      inst0_rs2_addr_i,
    input  logic [4:0]      inst1_rs1_addr_i,
    input  logic [4:0]      inst1_rs2_addr_i,
    output logic [XLEN-1:0] inst0_rs1_data_o,
    output logic [XLEN-1:0] inst0_rs2_data_o,
    output logic [XLEN-1:0] inst1_rs1_data_o,
    output logic [XLEN-1:0] inst1_rs2_data_o,
    output logic            rf_ready_o
);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] regs [32];
    logic            wr0_en, wr1_en;
    logic [4:0]      raddr [4];
    logic [XLEN-1:0] rdata [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StClear) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                state_d = StReady;
            end
        end
    end

    assign rf_ready_o = (state_q == StReady);
    assign wr0_en     = rf_ready_o && inst0_wb_valid_i && (inst0_wb_rd_i != 5'd0);
    assign wr1_en     = rf_ready_o && inst1_wb_valid_i && (inst1_wb_rd_i != 5'd0);

    // Storage has no reset; the sweep provides the architectural zero state.
    // Lane 1 is assigned last so it wins on a same-rd collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                regs[cnt_q] <= '0;
            end else begin
                if (wr0_en) begin
                    regs[inst0_wb_rd_i] <= inst0_wb_value_i;
                end
                if (wr1_en) begin
                    regs[inst1_wb_rd_i] <= inst1_wb_value_i;
                end
            end
        end
    end

    assign raddr[0] = inst0_rs1_addr_i;
    assign raddr[1] = inst0_rs2_addr_i;
    assign raddr[2] = inst1_rs1_addr_i;
    assign raddr[3] = inst1_rs2_addr_i;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rdata[i] = '0;
            if (rf_ready_o && (raddr[i] != 5'd0)) begin
                rdata[i] = regs[raddr[i]];
`ifdef RF_WB_BYPASS_EN
                if (wr0_en && (inst0_wb_rd_i == raddr[i])) begin
                    rdata[i] = inst0_wb_value_i;
                end
                if (wr1_en && (inst1_wb_rd_i == raddr[i])) begin
                    rdata[i] = inst1_wb_value_i;
                end
`endif
            end
        end
    end

    assign inst0_rs1_data_o = rdata[0];
    assign inst0_rs2_data_o = rdata[1];
    assign inst1_rs1_data_o = rdata[2];
    assign inst1_rs2_data_o = rdata[3];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared against an array-based architectural model.
module tb_wb_regfile;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            inst0_wb_valid_i, inst1_wb_valid_i;
    logic [4:0]      inst0_wb_rd_i, inst1_wb_rd_i;
    logic [XLEN-1:0] inst0_wb_value_i, inst1_wb_value_i;
    logic [4:0]      inst0_rs1_addr_i, inst0_rs2_addr_i, inst1_rs1_addr_i, inst1_rs2_addr_i;
    logic [XLEN-1:0] inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o;
    logic            rf_ready_o;

    logic [XLEN-1:0] model [32];
    int              n_checks = 0;
    int              n_fail   = 0;

    wb_regfile #(.XLEN(XLEN)) dut (
        .clk              (clk),
        .rst              (rst),
        .inst0_wb_valid_i (inst0_wb_valid_i),
        .inst0_wb_rd_i    (inst0_wb_rd_i),
        .inst0_wb_value_i (inst0_wb_value_i),
        .inst1_wb_valid_i (inst1_wb_valid_i),
        .inst1_wb_rd_i    (inst1_wb_rd_i),
        .inst1_wb_value_i (inst1_wb_value_i),
        .inst0_rs1_addr_i (inst0_rs1_addr_i),
        .inst0_rs2_addr_i (inst0_rs2_addr_i),
        .inst1_rs1_addr_i (inst1_rs1_addr_i),
        .inst1_rs2_addr_i (inst1_rs2_addr_i),
        .inst0_rs1_data_o (inst0_rs1_data_o),
        .inst0_rs2_data_o (inst0_rs2_data_o),
        .inst1_rs1_data_o (inst1_rs1_data_o),
        .inst1_rs2_data_o (inst1_rs2_data_o),
        .rf_ready_o       (rf_ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Expected read value in READY, given current write-port inputs.
    function automatic logic [XLEN-1:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return '0;
`ifdef RF_WB_BYPASS_EN
        if (inst1_wb_valid_i && inst1_wb_rd_i == a) return inst1_wb_value_i;
        if (inst0_wb_valid_i && inst0_wb_rd_i == a) return inst0_wb_value_i;
`endif
        return model[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        inst0_wb_valid_i = 1'b0; inst0_wb_rd_i = '0; inst0_wb_value_i = '0;
        inst1_wb_valid_i = 1'b0; inst1_wb_rd_i = '0; inst1_wb_value_i = '0;
        inst0_rs1_addr_i = '0; inst0_rs2_addr_i = '0;
        inst1_rs1_addr_i = '0; inst1_rs2_addr_i = '0;
    endtask

    task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [4:0] a3);
        inst0_rs1_addr_i = a0; inst0_rs2_addr_i = a1;
        inst1_rs1_addr_i = a2; inst1_rs2_addr_i = a3;
    endtask

    // Architectural effect of the pending writes (READY only).
    task automatic commit_model();
        if (inst0_wb_valid_i && inst0_wb_rd_i != 5'd0) model[inst0_wb_rd_i] = inst0_wb_value_i;
        if (inst1_wb_valid_i && inst1_wb_rd_i != 5'd0) model[inst1_wb_rd_i] = inst1_wb_value_i;
    endtask

    task automatic test_reset();
        set_idle();
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            set_reads(5'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()));
            #1;
            n_checks++;
            if (rf_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready_low cycle %0d: got %b want 0", i + 1, rf_ready_o);
            end
            n_checks++;
            if ({inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o} !== '0) begin
                n_fail++;
                $display("FAIL reset_clear_reads cycle %0d: got %h %h %h %h want 0", i + 1,
                         inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o);
            end
            tick();
        end
        n_checks++;
        if (rf_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_high cycle 33: got %b want 1", rf_ready_o);
        end
        for (int a = 0; a < 32; a++) begin
            model[a] = '0;
            set_reads(5'(a), 5'(a), 5'(a), 5'(a));
            #1;
            n_checks++;
            if ({inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o} !== '0) begin
                n_fail++;
                $display("FAIL reset_all_zero x%0d: got %h %h %h %h want 0", a,
                         inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o);
            end
        end
    endtask

    task automatic test_single_write();
        set_idle();
        inst0_wb_valid_i = 1'b1; inst0_wb_rd_i = 5'd5; inst0_wb_value_i = 64'h1234;
        commit_model();
        tick();
        set_idle();
        inst0_rs1_addr_i = 5'd5;
        #1;
        n_checks++;
        if (inst0_rs1_data_o !== 64'h1234) begin
            n_fail++;
            $display("FAIL single_write x5: got %h want 1234", inst0_rs1_data_o);
        end
    endtask

    task automatic test_dual_same_rd();
        set_idle();
        inst0_wb_valid_i = 1'b1; inst0_wb_rd_i = 5'd7; inst0_wb_value_i = 64'hAA;
        inst1_wb_valid_i = 1'b1; inst1_wb_rd_i = 5'd7; inst1_wb_value_i = 64'hBB;
        commit_model();
        tick();
        set_idle();
        set_reads(5'd7, 5'd7, 5'd7, 5'd7);
        #1;
        n_checks++;
        if ({inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o}
            !== {4{64'hBB}}) begin
            n_fail++;
            $display("FAIL dual_same_rd x7: got %h %h %h %h want bb", inst0_rs1_data_o,
                     inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o);
        end
    endtask

    task automatic test_x0();
        set_idle();
        inst0_wb_valid_i = 1'b1; inst0_wb_rd_i = 5'd0; inst0_wb_value_i = 64'hFFFF;
        inst1_wb_valid_i = 1'b1; inst1_wb_rd_i = 5'd0; inst1_wb_value_i = 64'hFFFF;
        #1;
        n_checks++;
        if ({inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o} !== '0) begin
            n_fail++;
            $display("FAIL x0_same_cycle: got %h %h %h %h want 0", inst0_rs1_data_o,
                     inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o);
        end
        tick();
        set_idle();
        #1;
        n_checks++;
        if ({inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o} !== '0) begin
            n_fail++;
            $display("FAIL x0_after_write: got %h %h %h %h want 0", inst0_rs1_data_o,
                     inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o);
        end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] want;
        set_idle();
        inst1_wb_valid_i = 1'b1; inst1_wb_rd_i = 5'd3; inst1_wb_value_i = 64'h11;
        commit_model();
        tick();
        set_idle();
        inst0_wb_valid_i = 1'b1; inst0_wb_rd_i = 5'd3; inst0_wb_value_i = 64'h22;
        set_reads(5'd3, 5'd3, 5'd3, 5'd3);
`ifdef RF_WB_BYPASS_EN
        want = 64'h22;
`else
        want = 64'h11;
`endif
        #1;
        n_checks++;
        if ({inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o}
            !== {4{want}}) begin
            n_fail++;
            $display("FAIL bypass_same_cycle x3: got %h %h %h %h want %h", inst0_rs1_data_o,
                     inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o, want);
        end
        commit_model();
        tick();
        inst0_wb_valid_i = 1'b0;
        #1;
        n_checks++;
        if (inst1_rs2_data_o !== 64'h22) begin
            n_fail++;
            $display("FAIL bypass_next_cycle x3: got %h want 22", inst1_rs2_data_o);
        end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] w0, w1, w2, w3;
        for (int n = 0; n < 300; n++) begin
            inst0_wb_valid_i = 1'($urandom());
            inst0_wb_rd_i    = 5'($urandom_range(0, 7));
            inst0_wb_value_i = rand64();
            inst1_wb_valid_i = 1'($urandom());
            inst1_wb_rd_i    = 5'($urandom_range(0, 7));
            inst1_wb_value_i = rand64();
            set_reads(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            w0 = exp_read(inst0_rs1_addr_i);
            w1 = exp_read(inst0_rs2_addr_i);
            w2 = exp_read(inst1_rs1_addr_i);
            w3 = exp_read(inst1_rs2_addr_i);
            n_checks++;
            if ({inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o}
                !== {w0, w1, w2, w3}) begin
                n_fail++;
                $display("FAIL random iter %0d: got %h %h %h %h want %h %h %h %h", n,
                         inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o,
                         inst1_rs2_data_o, w0, w1, w2, w3);
            end
            commit_model();
            tick();
        end
        set_idle();
    endtask

    task automatic test_reset_mid_sweep();
        set_idle();
        // Reset in READY with a concurrent write that must be discarded.
        inst0_wb_valid_i = 1'b1; inst0_wb_rd_i = 5'd4; inst0_wb_value_i = rand64();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        inst0_wb_rd_i = 5'd9; inst0_wb_value_i = rand64();
        inst1_wb_valid_i = 1'b1; inst1_wb_rd_i = 5'd10; inst1_wb_value_i = rand64();
        for (int i = 0; i < 20; i++) tick();
        #1;
        n_checks++;
        if (rf_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midsweep_ready_low_cnt20: got %b want 0", rf_ready_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                inst0_wb_valid_i = 1'b0;
                inst1_wb_valid_i = 1'b0;
            end
            #1;
            n_checks++;
            if (rf_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL midsweep_ready_low cycle %0d: got %b want 0", i + 1, rf_ready_o);
            end
            tick();
        end
        n_checks++;
        if (rf_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midsweep_ready_high cycle 33: got %b want 1", rf_ready_o);
        end
        for (int a = 0; a < 32; a++) begin
            model[a] = '0;
            set_reads(5'(a), 5'(a), 5'(a), 5'(a));
            #1;
            n_checks++;
            if ({inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o} !== '0) begin
                n_fail++;
                $display("FAIL midsweep_all_zero x%0d: got %h %h %h %h want 0", a,
                         inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o);
            end
        end
        set_idle();
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        test_reset();
        test_single_write();
        test_dual_same_rd();
        test_x0();
        test_bypass();
        test_random();
        test_reset_mid_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning register and data width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports inst0_wb_valid_i / inst1_wb_valid_i  input  1  per-lane write request from write-back.
REQ-005 SHALL have ports inst0_wb_rd_i / inst1_wb_rd_i  input  5  per-lane destination register index.
REQ-006 SHALL have ports inst0_wb_value_i / inst1_wb_value_i  input  XLEN  per-lane write data.
REQ-007 SHALL have ports inst0_rs1_addr_i, inst0_rs2_addr_i, inst1_rs1_addr_i, inst1_rs2_addr_i  input  5  read addresses for the two issue lanes.
REQ-008 SHALL have ports inst0_rs1_data_o, inst0_rs2_data_o, inst1_rs1_data_o, inst1_rs2_data_o  output  XLEN  read data.
REQ-009 SHALL have port rf_ready_o  output  1  high when the clear sweep is complete and the file accepts writes.

Function
REQ-010 SHALL hold 32 entries of XLEN bits in a non-resettable array, x0 excluded from storage semantics.
REQ-011 SHALL implement FSM states CLEAR and READY; rst forces CLEAR with sweep counter 0.
REQ-012 SHALL in CLEAR write zero to entry[counter] each cycle and increment the 5-bit counter.
REQ-013 SHALL go CLEAR->READY in the cycle after counter 31 is written; full sweep is exactly 32 cycles after rst deasserts.
REQ-014 SHALL drive rf_ready_o low in CLEAR and high in READY.
REQ-015 SHALL ignore inst0/inst1 write requests while in CLEAR; writes are not queued.
REQ-016 SHALL in READY, for each lane with valid=1 and rd!=0, store value at rd on the clock edge; visible to reads the next cycle.
REQ-017 SHALL on both lanes writing the same rd in one cycle store inst1_wb_value_i (inst1 is younger).
REQ-018 SHALL ignore writes to rd=0 and return 0 on any read of address 0.
REQ-019 SHALL provide all four reads combinationally (zero-cycle latency) from stored state, subject to REQ-026.
REQ-020 SHALL return 0 on all read outputs while in CLEAR.
REQ-021 SHALL treat valid=0 lanes as no-ops regardless of rd/value inputs.

Reset
REQ-022 SHALL, in any cycle with rst=1, set state to CLEAR, counter to 0, rf_ready_o to 0 on the following edge.
REQ-023 SHALL restart the sweep from entry 0 when rst asserts mid-sweep.
REQ-024 SHALL, when rst asserts in READY, discard the concurrent write and begin a fresh sweep.
REQ-025 SHALL not depend on array initial contents; all 31 architectural entries read 0 once rf_ready_o rises.

Configuration
REQ-026 SHALL, with macro RF_WB_BYPASS_EN defined and state READY, return on each read port the same-cycle write value when a valid lane writes that nonzero address (inst1 wins if both match); without the macro, reads return the stored (pre-write) value.
REQ-027 SHALL leave all other behaviour identical with and without RF_WB_BYPASS_EN.

Verification
REQ-028 SHALL cover: rst 1 cycle then release -> rf_ready_o low 32 cycles, high on 33rd; all reads 0.
REQ-029 SHALL cover: READY, inst0 write x5=0x1234 -> next cycle inst0_rs1_addr_i=5 reads 0x1234.
REQ-030 SHALL cover: both lanes write x7 (inst0 0xAA, inst1 0xBB) -> x7 reads 0xBB next cycle.
REQ-031 SHALL cover: write x0=0xFFFF -> x0 reads 0 on all four ports.
REQ-032 SHALL cover: x3 holds 0x11, same-cycle write x3=0x22 and read x3 -> 0x22 with RF_WB_BYPASS_EN, 0x11 without; 0x22 next cycle either way.
REQ-033 SHALL cover: rst at sweep counter 20, write attempted during CLEAR -> sweep restarts, write dropped, ready 32 cycles after rst release.
